// File: rtl/alu_accum.sv
// -----------------------------------------------------------------------------
// alu_accum
//   N-bit ALU with a 2N-bit result register. The low N bits of the result
//   register are fed back as operand B, so successive operations chain like an
//   accumulator. Single-cycle ops: add, or-reduce, and-reduce, concat,
//   subtract, rotate and hold. Multiply is unsigned shift-add over N cycles
//   plus one finish cycle, guarded by a Start/Busy/Done handshake.
//
// Ports
//   i_clock     rising-edge system clock
//   i_reset     asynchronous, active-high reset
//   i_a         [N-1:0]  operand A
//   i_function  [2:0]    operation select, sampled when Start is accepted
//   i_start     request to execute i_function (level-sampled every edge)
//   o_aluout    [2N-1:0] result register
//   o_carry     carry/borrow from the last add/sub (0 for other writes)
//   o_busy      multiply in progress
//   o_done      one-cycle pulse when an accepted operation completes
// -----------------------------------------------------------------------------
module alu_accum #(
    parameter int N = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N-1:0]     i_a,
    input  logic [2:0]       i_function,
    input  logic             i_start,
    output logic [2*N-1:0]   o_aluout,
    output logic             o_carry,
    output logic             o_busy,
    output logic             o_done
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_CAT  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ROT  = 3'b110;
    localparam logic [2:0] OP_HOLD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_aluout;
    logic            r_carry;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_mcand;   // multiplicand, shifted left one place per MUL cycle
    logic [N-1:0]    r_mplier;  // multiplier, shifted right so bit 0 is the current bit
    logic [W-1:0]    r_prod;
    logic [CW-1:0]   r_cnt;

    state_t          w_state_nxt;
    logic [W-1:0]    w_aluout_nxt;
    logic            w_carry_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [W-1:0]    w_mcand_nxt;
    logic [N-1:0]    w_mplier_nxt;
    logic [W-1:0]    w_prod_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    logic [N-1:0]    w_b;
    logic [N:0]      w_sum;
    logic [W-1:0]    w_diff;

    // Operand B feedback and the shared adder/subtractor datapath
    always_comb begin
        w_b    = r_aluout[N-1:0];
        w_sum  = {1'b0, i_a} + {1'b0, w_b};
        w_diff = {{N{1'b0}}, i_a} - {{N{1'b0}}, w_b};
    end

    // Next-state and datapath decode; everything holds unless an op is active
    always_comb begin
        w_state_nxt  = r_state;
        w_aluout_nxt = r_aluout;
        w_carry_nxt  = r_carry;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_prod_nxt   = r_prod;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // Busy is always low in IDLE, so Start alone means accept
                if (i_start) begin
                    if (i_function == OP_MUL) begin
                        w_mcand_nxt  = {{N{1'b0}}, i_a};
                        w_mplier_nxt = w_b;
                        w_prod_nxt   = {W{1'b0}};
                        w_cnt_nxt    = {CW{1'b0}};
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = ST_MUL;
                    end else begin
                        w_done_nxt = 1'b1;
                        case (i_function)
                            OP_ADD: begin
                                w_aluout_nxt = {{(N-1){1'b0}}, w_sum};
                                w_carry_nxt  = w_sum[N];
                            end
                            OP_OR: begin
                                w_aluout_nxt = {{(W-1){1'b0}}, |(i_a | w_b)};
                                w_carry_nxt  = 1'b0;
                            end
                            OP_AND: begin
                                w_aluout_nxt = {{(W-1){1'b0}}, &(i_a & w_b)};
                                w_carry_nxt  = 1'b0;
                            end
                            OP_CAT: begin
                                w_aluout_nxt = {i_a, w_b};
                                w_carry_nxt  = 1'b0;
                            end
                            OP_SUB: begin
                                w_aluout_nxt = w_diff;
                                w_carry_nxt  = (i_a < w_b) ? 1'b1 : 1'b0;
                            end
                            OP_ROT: begin
                                w_aluout_nxt = {r_aluout[W-2:0], r_aluout[W-1]};
                                w_carry_nxt  = 1'b0;
                            end
                            OP_HOLD: begin
                                w_aluout_nxt = r_aluout;
                                w_carry_nxt  = r_carry;
                            end
                            default: begin
                                w_aluout_nxt = r_aluout;
                                w_carry_nxt  = r_carry;
                            end
                        endcase
                    end
                end else begin
                    w_done_nxt = 1'b0;
                end
            end

            ST_MUL: begin
                // Shifting the multiplicand each cycle is the same as adding it
                // shifted by the counter; the counter only bounds the loop.
                if (r_mplier[0]) begin
                    w_prod_nxt = r_prod + r_mcand;
                end else begin
                    w_prod_nxt = r_prod;
                end
                w_mcand_nxt  = {r_mcand[W-2:0], 1'b0};
                w_mplier_nxt = {1'b0, r_mplier[N-1:1]};
                w_cnt_nxt    = r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_MUL;
                end
            end

            ST_FIN: begin
                w_aluout_nxt = r_prod;
                w_carry_nxt  = 1'b0;
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b1;
                w_state_nxt  = ST_IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any multiply in flight
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_aluout <= {W{1'b0}};
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= {W{1'b0}};
            r_mplier <= {N{1'b0}};
            r_prod   <= {W{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_aluout <= w_aluout_nxt;
            r_carry  <= w_carry_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_prod   <= w_prod_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign o_aluout = r_aluout;
    assign o_carry  = r_carry;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule
